// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: state encoding and opcode constants shared by the serial arithmetic unit
package serial_arith_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: one-bit full adder from two half adders and an OR
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    logic s0, c0, c1;
    half_adder u_ha0 (.a(a),  .b(b),    .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(c_in), .s(s),  .c(c1));
    assign c_out = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial add/subtract, one bit per clock LSB first, start/busy/done handshake
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic             fa_s, fa_c, last;

    fa_cell u_fa (.a(a_q[0]), .b(b_q[0]), .c_in(carry_q), .s(fa_s), .c_out(fa_c));

    assign last = cnt_q == CNT_W'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE && start) begin
            a_d     = a;
            b_d     = (sub == OP_SUB) ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            // carry_q is the carry into the MSB on the last bit
            if (last) begin
                c_out_d = fa_c;
                ovf_d   = carry_q ^ fa_c;
                state_d = S_DONE;
            end
        end else if (state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = state_q == S_RUN;
    assign done     = state_q == S_DONE;
    assign result   = res_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed scoreboard bench for the bit-serial adder/subtractor
module tb_serial_add_sub;
    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, c_out, overflow;
    logic [7:0] result;
    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];
    exp_t       e;

    serial_add_sub #(.WIDTH(8)) dut (
        .clk(clk), .reset(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] yy;
        logic [8:0] full;
        exp_t r;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {8'd0, s};
        r.r  = full[7:0];
        r.c  = full[8];
        r.o  = (x[7] == yy[7]) && (full[7] != x[7]);
        return r;
    endfunction

    // drive one accepted start; returns at the negedge just after the accepting edge
    task automatic start_op(input logic s, input logic [7:0] x, input logic [7:0] y, input bit push);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        if (push) sb.push_back(model(s, x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        int n = 0, nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, exp_n);
        chk({tag, "_busy_cycles"}, nb, exp_n);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("result", {24'd0, result}, {24'd0, e.r});
                chk("c_out", {31'd0, c_out}, {31'd0, e.c});
                chk("overflow", {31'd0, overflow}, {31'd0, e.o});
                chk("busy_with_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_cout_ovf", {30'd0, c_out, overflow}, 32'd0);
        rst = 1'b0;
        start_op(1'b0, 8'h35, 8'h4A, 1'b1); wait_done("add_35_4a", 8);
        start_op(1'b0, 8'hFF, 8'h01, 1'b1); wait_done("add_ff_01", 8);
        start_op(1'b0, 8'h7F, 8'h01, 1'b1); wait_done("add_7f_01", 8);
        start_op(1'b1, 8'h10, 8'h20, 1'b1); wait_done("sub_10_20", 8);
        start_op(1'b1, 8'h80, 8'h01, 1'b1); wait_done("sub_80_01", 8);
        start_op(1'b0, 8'h01, 8'h01, 1'b1);
        @(negedge clk);
        a = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", 6);
        start_op(1'b0, 8'h11, 8'h22, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_result", {24'd0, result}, 32'd0);
        chk("async_rst_cout_ovf", {30'd0, c_out, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        start_op(1'b0, 8'h02, 8'h03, 1'b1); wait_done("add_after_rst", 8);
        @(negedge clk);
        a = 8'h0A; b = 8'h05; sub = 1'b1; start = 1'b1;
        repeat (3) sb.push_back(model(1'b1, 8'h0A, 8'h05));
        @(negedge clk);
        wait_done("held_0", 8);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            @(negedge clk);
            wait_done("held_n", 8);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
